// File: rtl/lcd_refresh_ctrl.sv
// Continuous refresh sequencer for a 2x16 character LCD on a 4-bit bus.
// Streams two address commands and 32 stored characters per frame, then idles for a frame gap.
module lcd_refresh_ctrl #(
    parameter int T_SETUP     = 2,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 1,
    parameter int T_NIB_GAP   = 50,
    parameter int T_BYTE_GAP  = 2000,
    parameter int T_FRAME_GAP = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic [7:0] char_data,
    output logic [4:0] char_addr,
    output logic [3:0] lcd_db,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       busy,
    output logic       frame_done
);

    localparam int M1    = (T_SETUP > T_EN) ? T_SETUP : T_EN;
    localparam int M2    = (M1 > T_HOLD) ? M1 : T_HOLD;
    localparam int M3    = (M2 > T_NIB_GAP) ? M2 : T_NIB_GAP;
    localparam int M4    = (M3 > T_BYTE_GAP) ? M3 : T_BYTE_GAP;
    localparam int T_MAX = (M4 > T_FRAME_GAP) ? M4 : T_FRAME_GAP;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] LD_EN    = TW'(T_EN - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);
    localparam logic [TW-1:0] LD_NIB   = TW'(T_NIB_GAP - 1);
    localparam logic [TW-1:0] LD_BYTE  = TW'(T_BYTE_GAP - 1);
    localparam logic [TW-1:0] LD_FRAME = TW'(T_FRAME_GAP - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] N_SETUP   = 3'd2;
    localparam logic [2:0] N_EN      = 3'd3;
    localparam logic [2:0] N_HOLD    = 3'd4;
    localparam logic [2:0] N_GAP     = 3'd5;
    localparam logic [2:0] FRAME_GAP = 3'd6;

    localparam logic [5:0] LAST_IDX = 6'd33;

    logic [2:0]    state;
    logic          fetch_second;
    logic          nib_hi;
    logic [5:0]    idx;
    logic [TW-1:0] timer;
    logic [3:0]    lo_nibble;
    logic          is_cmd;
    logic [7:0]    cmd_byte;
    logic [7:0]    byte_in;

    // Command slots point at the first character of the line that follows them.
    function automatic logic [4:0] addr_of(input logic [5:0] i);
        logic [5:0] a;
        if (i == 6'd0)
            a = 6'd0;
        else if (i <= 6'd17)
            a = i - 6'd1;
        else
            a = i - 6'd2;
        return a[4:0];
    endfunction

    assign is_cmd   = (idx == 6'd0) || (idx == 6'd17);
    assign cmd_byte = (idx == 6'd0) ? 8'h80 : 8'hC0;
    assign byte_in  = is_cmd ? cmd_byte : char_data;

    assign lcd_e  = (state == N_EN);
    assign busy   = (state != IDLE) && (state != FRAME_GAP);
    assign lcd_rw = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            fetch_second <= 1'b0;
            nib_hi       <= 1'b0;
            idx          <= 6'd0;
            timer        <= '0;
            lo_nibble    <= 4'd0;
            char_addr    <= 5'd0;
            lcd_db       <= 4'd0;
            lcd_rs       <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_done) begin
                        state        <= FETCH;
                        fetch_second <= 1'b0;
                        idx          <= 6'd0;
                        char_addr    <= addr_of(6'd0);
                    end
                end
                FETCH: begin
                    if (!fetch_second) begin
                        fetch_second <= 1'b1;
                        lcd_rs       <= ~is_cmd;
                    end else begin
                        // char_data now reflects the address issued in the first FETCH cycle.
                        fetch_second <= 1'b0;
                        lcd_db       <= byte_in[7:4];
                        lo_nibble    <= byte_in[3:0];
                        nib_hi       <= 1'b1;
                        timer        <= LD_SETUP;
                        state        <= N_SETUP;
                    end
                end
                N_SETUP: begin
                    if (timer == '0) begin
                        state <= N_EN;
                        timer <= LD_EN;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                N_EN: begin
                    if (timer == '0) begin
                        state <= N_HOLD;
                        timer <= LD_HOLD;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                N_HOLD: begin
                    if (timer == '0) begin
                        state <= N_GAP;
                        timer <= nib_hi ? LD_NIB : LD_BYTE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                N_GAP: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (nib_hi) begin
                        nib_hi <= 1'b0;
                        lcd_db <= lo_nibble;
                        timer  <= LD_SETUP;
                        state  <= N_SETUP;
                    end else if (idx == LAST_IDX) begin
                        frame_done <= 1'b1;
                        timer      <= LD_FRAME;
                        state      <= FRAME_GAP;
                    end else begin
                        idx          <= idx + 6'd1;
                        char_addr    <= addr_of(idx + 6'd1);
                        fetch_second <= 1'b0;
                        state        <= FETCH;
                    end
                end
                FRAME_GAP: begin
                    if (timer == '0) begin
                        idx          <= 6'd0;
                        char_addr    <= addr_of(6'd0);
                        fetch_second <= 1'b0;
                        state        <= FETCH;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Self-checking bench for lcd_refresh_ctrl: a cycle-position model of the refresh frame
// plus a table of hand-computed values at fixed points of the sequence.
module tb_lcd_refresh_ctrl;

    localparam int S  = 1;
    localparam int E  = 2;
    localparam int H  = 1;
    localparam int NG = 3;
    localparam int BG = 5;
    localparam int FG = 10;
    localparam int B  = 2 + 2 * (S + E + H) + NG + BG;
    localparam int FR = 34 * B;
    localparam int P  = FR + FG;
    localparam int LO_START = 2 + S + E + H + NG;

    localparam int SIG_DB = 0, SIG_E = 1, SIG_RS = 2, SIG_ADDR = 3, SIG_BUSY = 4, SIG_FDONE = 5;

    typedef struct {
        int run;
        int t;
        int sig;
        int val;
    } lit_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_done;
    logic [7:0] char_data;
    logic [4:0] char_addr;
    logic [3:0] lcd_db;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [32];
    lit_t       lits[$];

    int checks = 0;
    int failures = 0;

    logic started = 1'b0;
    logic running = 1'b0;
    int   t = 0;
    int   run = 0;

    logic was_running = 1'b0;
    logic prev_e = 1'b0;
    int   e_rises = 0;

    always #5 clk = ~clk;

    lcd_refresh_ctrl #(
        .T_SETUP(S), .T_EN(E), .T_HOLD(H),
        .T_NIB_GAP(NG), .T_BYTE_GAP(BG), .T_FRAME_GAP(FG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init_done(init_done),
        .char_data(char_data),
        .char_addr(char_addr),
        .lcd_db(lcd_db),
        .lcd_e(lcd_e),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .busy(busy),
        .frame_done(frame_done)
    );

    // Character store with one cycle of read latency.
    always @(posedge clk) char_data <= mem[char_addr];

    // Model position: t counts cycles since the controller left IDLE.
    always @(posedge clk) begin
        if (reset) begin
            started <= 1'b1;
            running <= 1'b0;
        end else if (!running && init_done) begin
            running <= 1'b1;
            t       <= 0;
            run     <= run + 1;
        end else if (running) begin
            t <= t + 1;
        end
    end

    function automatic logic [7:0] byte_of(input int b);
        if (b == 0)       return 8'h80;
        else if (b == 17) return 8'hC0;
        else if (b <= 16) return mem[b - 1];
        else              return mem[b - 2];
    endfunction

    function automatic int rs_of(input int b);
        return (b == 0 || b == 17) ? 0 : 1;
    endfunction

    function automatic int addr_of(input int b);
        if (b == 0)       return 0;
        else if (b <= 17) return b - 1;
        else              return b - 2;
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            SIG_DB:    return int'(lcd_db);
            SIG_E:     return int'(lcd_e);
            SIG_RS:    return int'(lcd_rs);
            SIG_ADDR:  return int'(char_addr);
            SIG_BUSY:  return int'(busy);
            default:   return int'(frame_done);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s run=%0d t=%0d actual=%0h expected=%0h", name, run, t, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic i);
        reset     = r;
        init_done = i;
    endtask

    task automatic waitForT(input int r, input int tt);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (run == r && t == tt && running) return;
        end
        failures++;
        $display("[TB] FAIL wait_timeout run=%0d t=%0d actual=none expected=t%0d", run, t, tt);
        $fatal(1, "[TB] sequence position never reached");
    endtask

    always @(negedge clk) begin
        int f, b, o;
        logic [7:0] v;
        if (started) begin
            checkOutput("rw", lcd_rw, 0);
            if (!running) begin
                if (was_running) checkOutput("e_after_reset", lcd_e, 0);
                checkOutput("idle_e", lcd_e, 0);
                checkOutput("idle_busy", busy, 0);
                checkOutput("idle_fdone", frame_done, 0);
                checkOutput("idle_db", lcd_db, 0);
                checkOutput("idle_rs", lcd_rs, 0);
                checkOutput("idle_addr", char_addr, 0);
                e_rises = 0;
            end else begin
                f = t % P;
                if (f >= FR) begin
                    checkOutput("gap_busy", busy, 0);
                    checkOutput("gap_e", lcd_e, 0);
                    checkOutput("gap_fdone", frame_done, (f == FR) ? 1 : 0);
                    checkOutput("gap_addr", char_addr, 31);
                    checkOutput("gap_rs", lcd_rs, 1);
                    checkOutput("gap_db", lcd_db, int'(mem[31][3:0]));
                end else begin
                    b = f / B;
                    o = f % B;
                    v = byte_of(b);
                    checkOutput("busy", busy, 1);
                    checkOutput("fdone", frame_done, 0);
                    checkOutput("addr", char_addr, addr_of(b));
                    checkOutput("e", lcd_e,
                        ((o >= 2 + S && o < 2 + S + E) ||
                         (o >= LO_START + S && o < LO_START + S + E)) ? 1 : 0);
                    if (o >= 1)
                        checkOutput("rs", lcd_rs, rs_of(b));
                    else if (b > 0)
                        checkOutput("rs_prev", lcd_rs, rs_of(b - 1));
                    else
                        checkOutput("rs_prev", lcd_rs, (t < P) ? 0 : 1);
                    if (o >= LO_START)
                        checkOutput("db_lo", lcd_db, int'(v[3:0]));
                    else if (o >= 2)
                        checkOutput("db_hi", lcd_db, int'(v[7:4]));
                    else if (b > 0)
                        checkOutput("db_prev", lcd_db, int'(byte_of(b - 1) & 8'h0F));
                    else
                        checkOutput("db_prev", lcd_db, (t < P) ? 0 : int'(mem[31][3:0]));
                end
                if (t == 0) e_rises = 0;
                if (lcd_e && !prev_e) e_rises++;
                if (run == 1 && t == FR) checkOutput("e_pulses_per_frame", e_rises, 68);
                foreach (lits[k]) begin
                    if (lits[k].run == run && lits[k].t == t)
                        checkOutput($sformatf("lit_sig%0d", lits[k].sig), sig_val(lits[k].sig), lits[k].val);
                end
            end
            was_running = running;
            prev_e = lcd_e;
        end
    end

    initial begin
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 32; i++) mem[i] = 8'h41 + 8'(i);
        mem[16] = 8'h5A;

        // Byte 0: command 0x80.
        lits.push_back(lit_t'{1, 2, SIG_DB, 8});
        lits.push_back(lit_t'{1, 2, SIG_RS, 0});
        lits.push_back(lit_t'{1, 2, SIG_E, 0});
        lits.push_back(lit_t'{1, 3, SIG_E, 1});
        lits.push_back(lit_t'{1, 4, SIG_E, 1});
        lits.push_back(lit_t'{1, 5, SIG_E, 0});
        lits.push_back(lit_t'{1, 5, SIG_DB, 8});
        lits.push_back(lit_t'{1, 9, SIG_DB, 0});
        lits.push_back(lit_t'{1, 10, SIG_E, 1});
        lits.push_back(lit_t'{1, 11, SIG_E, 1});
        lits.push_back(lit_t'{1, 12, SIG_E, 0});
        // Byte 1: 'A' from address 0.
        lits.push_back(lit_t'{1, 18, SIG_ADDR, 0});
        lits.push_back(lit_t'{1, 19, SIG_RS, 1});
        lits.push_back(lit_t'{1, 20, SIG_DB, 4});
        lits.push_back(lit_t'{1, 21, SIG_E, 1});
        lits.push_back(lit_t'{1, 27, SIG_DB, 1});
        lits.push_back(lit_t'{1, 28, SIG_E, 1});
        // Byte 17: command 0xC0, byte 18: address 16 holding 0x5A.
        lits.push_back(lit_t'{1, 308, SIG_DB, 12});
        lits.push_back(lit_t'{1, 308, SIG_RS, 0});
        lits.push_back(lit_t'{1, 315, SIG_DB, 0});
        lits.push_back(lit_t'{1, 324, SIG_ADDR, 16});
        lits.push_back(lit_t'{1, 326, SIG_DB, 5});
        lits.push_back(lit_t'{1, 333, SIG_DB, 10});
        // Frame boundary.
        lits.push_back(lit_t'{1, 611, SIG_FDONE, 0});
        lits.push_back(lit_t'{1, 612, SIG_FDONE, 1});
        lits.push_back(lit_t'{1, 612, SIG_BUSY, 0});
        lits.push_back(lit_t'{1, 613, SIG_FDONE, 0});
        lits.push_back(lit_t'{1, 621, SIG_BUSY, 0});
        lits.push_back(lit_t'{1, 622, SIG_BUSY, 1});
        lits.push_back(lit_t'{1, 622, SIG_ADDR, 0});
        lits.push_back(lit_t'{1, 624, SIG_DB, 8});
        lits.push_back(lit_t'{1, 624, SIG_RS, 0});
        // Second N_EN cycle of byte 5 in frame 2, just before reset.
        lits.push_back(lit_t'{1, 716, SIG_E, 1});
        // Restart after reset.
        lits.push_back(lit_t'{2, 0, SIG_ADDR, 0});
        lits.push_back(lit_t'{2, 2, SIG_DB, 8});
        lits.push_back(lit_t'{2, 2, SIG_RS, 0});
        lits.push_back(lit_t'{2, 3, SIG_E, 1});

        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (50) @(negedge clk);
        $display("[TB] raising init_done");
        applyStimulus(1'b0, 1'b1);

        // Dropping init_done mid-run must not stop the refresh.
        waitForT(1, 100);
        applyStimulus(1'b0, 1'b0);
        waitForT(1, 700);
        applyStimulus(1'b0, 1'b1);

        waitForT(1, 716);
        $display("[TB] reset during enable pulse of byte 5");
        applyStimulus(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b1);

        waitForT(2, 700);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
